// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Valid/ready: a requester holds in_req and its byte until its out_ack pulse; the byte is taken in the arbitration cycle only.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_WIDTH      = 32,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic [NUM_REQ-1:0]            in_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            out_ack,
  output logic [IDW-1:0]                out_grant_id,
  output logic                          out_busy,
  output logic                          out_timeout,
  output logic                          out_tx_start,
  output logic [DATA_WIDTH-1:0]         out_tx_data,
  input  logic                          in_tx_done,
  output logic                          out_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [IDW-1:0]       LAST_ID  = IDW'(NUM_REQ - 1);

  state_t                  state, state_n;
  logic [IDW-1:0]          ptr, ptr_n;
  logic [CNT_WIDTH-1:0]    cnt, cnt_n;
  logic                    found;
  logic [IDW-1:0]          sel;
  logic                    timeout_hit;
  logic [IDW-1:0]          ptr_adv;
  logic [NUM_REQ-1:0]      ack_n;
  logic                    start_n, busy_n, timeout_n;
  logic [DATA_WIDTH-1:0]   data_n;
  logic [IDW-1:0]          gid_n;

  assign out_state = state;

  // Search upward from the pointer with wrap-around; first set bit wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && in_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // The counter sits at the limit for one full cycle before the abort is taken.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LIMIT);
  assign ptr_adv     = (out_grant_id == LAST_ID) ? '0 : out_grant_id + 1'b1;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (found) state_n = S_WAIT;
      S_WAIT: if (in_tx_done || timeout_hit) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ack_n     = '0;
    start_n   = 1'b0;
    timeout_n = 1'b0;
    busy_n    = out_busy;
    data_n    = out_tx_data;
    gid_n     = out_grant_id;
    ptr_n     = ptr;
    cnt_n     = cnt;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          ack_n[sel] = 1'b1;
          start_n    = 1'b1;
          busy_n     = 1'b1;
          data_n     = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
          gid_n      = sel;
          cnt_n      = '0;
        end
      end
      S_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (in_tx_done) begin
          busy_n = 1'b0;
          ptr_n  = ptr_adv;
        end else if (timeout_hit) begin
          timeout_n = 1'b1;
          busy_n    = 1'b0;
          ptr_n     = ptr_adv;
        end
      end
      default: busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_ack      <= '0;
      out_tx_start <= 1'b0;
      out_timeout  <= 1'b0;
      out_busy     <= 1'b0;
      out_tx_data  <= '0;
      out_grant_id <= '0;
      ptr          <= '0;
      cnt          <= '0;
    end else begin
      out_ack      <= ack_n;
      out_tx_start <= start_n;
      out_timeout  <= timeout_n;
      out_busy     <= busy_n;
      out_tx_data  <= data_n;
      out_grant_id <= gid_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, latency, timeout, async reset and spurious-input cases.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)
  ) dut (
    .in_clk(clk), .in_rst(rst_n), .in_req(req), .in_data(data),
    .out_ack(ack), .out_grant_id(grant_id), .out_busy(busy),
    .out_timeout(timeout), .out_tx_start(tx_start), .out_tx_data(tx_data),
    .in_tx_done(tx_done), .out_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer from IDLE: start on the next edge, done one cycle after start.
  task automatic transfer(input int id);
    logic [7:0] eb;
    logic [3:0] ea;
    ea = 4'b0001 << id;
    eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    step();
    check("start_pulse", {31'd0, tx_start}, 32'd1);
    check("ack_onehot", {28'd0, ack}, {28'd0, ea});
    check("grant_id", {30'd0, grant_id}, id);
    check("tx_data", {24'd0, tx_data}, {24'd0, eb});
    check("busy_set", {31'd0, busy}, 32'd1);
    step();
    check("start_clear", {31'd0, tx_start}, 32'd0);
    check("ack_clear", {28'd0, ack}, 32'd0);
    check("busy_hold", {31'd0, busy}, 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("no_timeout", {31'd0, timeout}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {28'd0, ack}, 32'd0);
    check({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_gid"}, {30'd0, grant_id}, 32'd0);
    check({tag, "_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; data = '0; tx_done = 1'b0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // single requester 2
    data[16 +: 8] = 8'hA5;
    req = 4'b0100;
    exp_q.push_back(8'hA5);
    transfer(2);
    req = 4'b0000;

    // pointer is 3: wrap to 0, then 1 while 0 keeps requesting
    data[0 +: 8] = 8'h5A;
    data[8 +: 8] = 8'h3C;
    req = 4'b0011;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3C);
    transfer(0);
    transfer(1);
    req = 4'b0000;

    // spurious done in IDLE, then a request withdrawn between edges
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("spur_done_busy", {31'd0, busy}, 32'd0);
    check("spur_done_start", {31'd0, tx_start}, 32'd0);
    req = 4'b1000;
    #2;
    req = 4'b0000;
    step();
    check("withdraw_ack", {28'd0, ack}, 32'd0);
    check("withdraw_start", {31'd0, tx_start}, 32'd0);
    check("withdraw_busy", {31'd0, busy}, 32'd0);

    // timeout: pointer 2 grants 2, no done, then pending 1 is granted
    data[8 +: 8]  = 8'h61;
    data[16 +: 8] = 8'h62;
    req = 4'b0110;
    step();
    check("to_start", {31'd0, tx_start}, 32'd1);
    check("to_gid", {30'd0, grant_id}, 32'd2);
    check("to_data", {24'd0, tx_data}, 32'h62);
    req = 4'b0010;
    n = 0;
    while (!timeout && n < 40) begin
      step();
      n++;
    end
    check("to_latency", n, 32'd17);
    check("to_busy_fall", {31'd0, busy}, 32'd0);
    step();
    check("to_pulse_width", {31'd0, timeout}, 32'd0);
    check("after_to_start", {31'd0, tx_start}, 32'd1);
    check("after_to_gid", {30'd0, grant_id}, 32'd1);
    check("after_to_ack", {28'd0, ack}, 32'b0010);
    check("after_to_data", {24'd0, tx_data}, 32'h61);
    req = 4'b0000;
    repeat (16) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("done_wins_timeout", {31'd0, timeout}, 32'd0);
    check("done_wins_busy", {31'd0, busy}, 32'd0);
    step();
    check("done_wins_late", {31'd0, timeout}, 32'd0);

    // async reset while the start pulse is high
    data[8 +: 8]  = 8'h71;
    data[24 +: 8] = 8'h73;
    req = 4'b1010;
    step();
    check("pre_rst_start", {31'd0, tx_start}, 32'd1);
    check("pre_rst_gid", {30'd0, grant_id}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    #3;
    rst_n = 1'b1;
    exp_q.push_back(8'h71);
    transfer(1);
    req = 4'b0000;

    // fresh pointer, all four requesting
    #2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req = 4'b1111;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hD4);
    exp_q.push_back(8'hA1);
    transfer(0);
    transfer(1);
    transfer(2);
    transfer(3);
    transfer(0);
    req = 4'b0000;
    step();
    check("final_busy", {31'd0, busy}, 32'd0);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
